// File: rtl/ats21_pkg.sv
// Shared types and widths for the ATS21 two-client front end.
package ats21_pkg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 24;
    localparam int STAT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    typedef enum logic {
        CLIENT_A,
        CLIENT_B
    } client_e;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrlA;
        logic [CTRL_W-1:0] ctrlB;
    } ats_cmd_t;

endpackage

// File: rtl/ats21_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes
// to whichever client did not own the ATS21 last.
module ats21_rr_arb2
    import ats21_pkg::*;
(
    input  logic    a_req,
    input  logic    b_req,
    input  client_e last_owner,
    output client_e winner,
    output logic    valid
);

    // Pick the winner from the current requests and the previous owner
    always_comb begin
        valid  = a_req | b_req;
        winner = CLIENT_A;
        if (a_req && b_req) begin
            winner = (last_owner == CLIENT_A) ? CLIENT_B : CLIENT_A;
        end else if (b_req) begin
            winner = CLIENT_B;
        end
    end

endmodule

// File: rtl/ats21_client_arbiter.sv
// Front end that shares one ATS21 request port between clients A and B.
// One command per IDLE -> ISSUE -> RESP pass; ISSUE waits for ats_ready
// and gives up with a timeout response after TIMEOUT cycles.
module ats21_client_arbiter #(
    parameter int CTRL_W  = ats21_pkg::CTRL_W,
    parameter int DATA_W  = ats21_pkg::DATA_W,
    parameter int STAT_W  = ats21_pkg::STAT_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [CTRL_W-1:0] a_ctrlA,
    input  logic [CTRL_W-1:0] a_ctrlB,
    input  logic              b_req,
    input  logic [CTRL_W-1:0] b_ctrlA,
    input  logic [CTRL_W-1:0] b_ctrlB,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_done,
    output logic              b_done,
    output logic [STAT_W-1:0] rsp_stat,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              ats_req,
    output logic [CTRL_W-1:0] ats_ctrlA,
    output logic [CTRL_W-1:0] ats_ctrlB,
    input  logic              ats_ready,
    input  logic [STAT_W-1:0] ats_stat,
    input  logic [DATA_W-1:0] ats_data
);

    import ats21_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT + 1);

    arb_state_e      state;
    client_e         owner;
    client_e         last_owner;
    client_e         pick_winner;
    logic            pick_valid;
    logic [TO_W-1:0] timeout_cnt;

    ats21_rr_arb2 u_rr_arb2 (
        .a_req      (a_req),
        .b_req      (b_req),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // Transaction FSM; every output is a register updated here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= CLIENT_A;
            last_owner  <= CLIENT_B;
            timeout_cnt <= '0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            rsp_stat    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            ats_req     <= 1'b0;
            ats_ctrlA   <= '0;
            ats_ctrlB   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick_winner;
                        ats_ctrlA   <= (pick_winner == CLIENT_A) ? a_ctrlA : b_ctrlA;
                        ats_ctrlB   <= (pick_winner == CLIENT_A) ? a_ctrlB : b_ctrlB;
                        a_gnt       <= (pick_winner == CLIENT_A);
                        b_gnt       <= (pick_winner == CLIENT_B);
                        ats_req     <= 1'b1;
                        busy        <= 1'b1;
                        timeout_cnt <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ats_ready) begin
                        rsp_stat    <= ats_stat;
                        rsp_data    <= ats_data;
                        rsp_timeout <= 1'b0;
                        a_done      <= (owner == CLIENT_A);
                        b_done      <= (owner == CLIENT_B);
                        ats_req     <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_cnt == TO_W'(TIMEOUT - 1)) begin
                        rsp_stat    <= '0;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        a_done      <= (owner == CLIENT_A);
                        b_done      <= (owner == CLIENT_B);
                        ats_req     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                RESP: begin
                    a_done      <= 1'b0;
                    b_done      <= 1'b0;
                    a_gnt       <= 1'b0;
                    b_gnt       <= 1'b0;
                    busy        <= 1'b0;
                    rsp_timeout <= 1'b0;
                    last_owner  <= owner;
                    timeout_cnt <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ats21_client_arbiter.sv
// Directed bench for ats21_client_arbiter with hand-computed expectations.
module tb_ats21_client_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0;
    logic [15:0] a_ctrlA = '0;
    logic [15:0] a_ctrlB = '0;
    logic        b_req = 1'b0;
    logic [15:0] b_ctrlA = '0;
    logic [15:0] b_ctrlB = '0;
    logic        a_gnt, b_gnt, a_done, b_done;
    logic [1:0]  rsp_stat;
    logic [23:0] rsp_data;
    logic        rsp_timeout, busy, ats_req;
    logic [15:0] ats_ctrlA, ats_ctrlB;
    logic        ats_ready = 1'b0;
    logic [1:0]  ats_stat = '0;
    logic [23:0] ats_data = '0;

    int vec_count = 0;
    int miss_count = 0;

    ats21_client_arbiter #(.TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_req       (a_req),
        .a_ctrlA     (a_ctrlA),
        .a_ctrlB     (a_ctrlB),
        .b_req       (b_req),
        .b_ctrlA     (b_ctrlA),
        .b_ctrlB     (b_ctrlB),
        .a_gnt       (a_gnt),
        .b_gnt       (b_gnt),
        .a_done      (a_done),
        .b_done      (b_done),
        .rsp_stat    (rsp_stat),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .ats_req     (ats_req),
        .ats_ctrlA   (ats_ctrlA),
        .ats_ctrlB   (ats_ctrlB),
        .ats_ready   (ats_ready),
        .ats_stat    (ats_stat),
        .ats_data    (ats_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ar, input logic [15:0] aa, input logic [15:0] ab,
                                 input logic br, input logic [15:0] ba, input logic [15:0] bb);
        a_req   = ar;
        a_ctrlA = aa;
        a_ctrlB = ab;
        b_req   = br;
        b_ctrlA = ba;
        b_ctrlB = bb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant and done exclusivity checked every cycle
    always @(negedge clk) begin
        checkOutput("gnt_excl", {31'b0, a_gnt & b_gnt}, 32'd0);
        checkOutput("done_excl", {31'b0, a_done & b_done}, 32'd0);
    end

    initial begin
        int cnt;
        logic exp_a;

        // Reset values
        tick();
        tick();
        checkOutput("rst_ats_req", ats_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_gnt", {a_gnt, b_gnt}, 0);
        checkOutput("rst_ctrlA", ats_ctrlA, 0);
        reset = 1'b0;

        // Single A command, ready on second ISSUE edge
        applyStimulus(1, 16'h1234, 16'h0005, 0, 16'h0, 16'h0);
        tick();
        checkOutput("t1_ats_req", ats_req, 1);
        checkOutput("t1_a_gnt", a_gnt, 1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_ctrlA", ats_ctrlA, 32'h1234);
        checkOutput("t1_ctrlB", ats_ctrlB, 32'h0005);
        tick();
        checkOutput("t1_req_hold", ats_req, 1);
        checkOutput("t1_no_done", a_done, 0);
        ats_ready = 1'b1; ats_stat = 2'b01; ats_data = 24'h000003;
        tick();
        checkOutput("t1_a_done", a_done, 1);
        checkOutput("t1_stat", rsp_stat, 1);
        checkOutput("t1_data", rsp_data, 3);
        checkOutput("t1_timeout", rsp_timeout, 0);
        checkOutput("t1_resp_req", ats_req, 0);
        checkOutput("t1_resp_gnt", a_gnt, 1);
        checkOutput("t1_resp_busy", busy, 1);
        ats_ready = 1'b0;
        applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("t1_idle_done", a_done, 0);
        checkOutput("t1_idle_gnt", a_gnt, 0);
        checkOutput("t1_idle_busy", busy, 0);
        checkOutput("t1_data_hold", rsp_data, 3);

        // Round-robin with both clients held, ready immediate
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        applyStimulus(1, 16'hA001, 16'hA002, 1, 16'hB001, 16'hB002);
        ats_ready = 1'b1; ats_stat = 2'b11; ats_data = 24'hABCDEF;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            tick();
            checkOutput("rr_gnt_a", a_gnt, exp_a);
            checkOutput("rr_gnt_b", b_gnt, !exp_a);
            checkOutput("rr_ctrlA", ats_ctrlA, exp_a ? 32'hA001 : 32'hB001);
            checkOutput("rr_ctrlB", ats_ctrlB, exp_a ? 32'hA002 : 32'hB002);
            tick();
            checkOutput("rr_done_a", a_done, exp_a);
            checkOutput("rr_done_b", b_done, !exp_a);
            checkOutput("rr_data", rsp_data, 32'hABCDEF);
            if (i == 3) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
            tick();
            checkOutput("rr_idle_done", {a_done, b_done}, 0);
            checkOutput("rr_idle_gnt", {a_gnt, b_gnt}, 0);
        end
        ats_ready = 1'b0;

        // B alone, no ready: timeout after 64 ISSUE cycles
        applyStimulus(0, 16'h0, 16'h0, 1, 16'hC0DE, 16'h0BAD);
        tick();
        checkOutput("to_b_gnt", b_gnt, 1);
        checkOutput("to_ctrlA", ats_ctrlA, 32'hC0DE);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!ats_req) break;
            cnt++;
            tick();
        end
        checkOutput("to_req_cycles", cnt, 64);
        checkOutput("to_b_done", b_done, 1);
        checkOutput("to_flag", rsp_timeout, 1);
        checkOutput("to_stat", rsp_stat, 0);
        checkOutput("to_data", rsp_data, 0);
        applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("to_idle_flag", rsp_timeout, 0);
        checkOutput("to_idle_done", b_done, 0);
        checkOutput("to_idle_busy", busy, 0);

        // Ready arriving on the same edge as the timeout wins
        applyStimulus(1, 16'h4444, 16'h5555, 0, 16'h0, 16'h0);
        tick();
        checkOutput("edge_a_gnt", a_gnt, 1);
        repeat (63) tick();
        checkOutput("edge_req_hold", ats_req, 1);
        ats_ready = 1'b1; ats_stat = 2'b10; ats_data = 24'h5A5A5A;
        tick();
        checkOutput("edge_a_done", a_done, 1);
        checkOutput("edge_flag", rsp_timeout, 0);
        checkOutput("edge_stat", rsp_stat, 2);
        checkOutput("edge_data", rsp_data, 32'h5A5A5A);
        ats_ready = 1'b0;
        applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        tick();

        // Asynchronous reset mid-ISSUE, then A wins the tie
        applyStimulus(0, 16'h0, 16'h0, 1, 16'hB0B0, 16'h0000);
        tick();
        checkOutput("mr_b_gnt", b_gnt, 1);
        applyStimulus(1, 16'hA5A5, 16'h0001, 1, 16'hB0B0, 16'h0000);
        #2 reset = 1'b1;
        #1;
        checkOutput("mr_ats_req", ats_req, 0);
        checkOutput("mr_b_gnt_drop", b_gnt, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_ctrlA", ats_ctrlA, 0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("mr_tie_a", a_gnt, 1);
        checkOutput("mr_tie_b", b_gnt, 0);
        checkOutput("mr_tie_ctrl", ats_ctrlA, 32'hA5A5);
        ats_ready = 1'b1; ats_stat = 2'b01; ats_data = 24'h000042;
        tick();
        checkOutput("mr_a_done", a_done, 1);
        ats_ready = 1'b0;
        applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        tick();

        // Request dropped during ISSUE, stray ready while idle
        applyStimulus(1, 16'h6666, 16'h7777, 0, 16'h0, 16'h0);
        tick();
        a_req = 1'b0;
        tick();
        checkOutput("drop_req_hold", ats_req, 1);
        checkOutput("drop_gnt_hold", a_gnt, 1);
        ats_ready = 1'b1; ats_stat = 2'b01; ats_data = 24'h000777;
        tick();
        checkOutput("drop_a_done", a_done, 1);
        checkOutput("drop_data", rsp_data, 32'h000777);
        ats_ready = 1'b0;
        tick();
        ats_ready = 1'b1; ats_data = 24'h00FFFF;
        repeat (2) begin
            tick();
            checkOutput("stray_done", {a_done, b_done}, 0);
            checkOutput("stray_req", ats_req, 0);
            checkOutput("stray_busy", busy, 0);
        end
        ats_ready = 1'b0;
        checkOutput("stray_data_hold", rsp_data, 32'h000777);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/ats21_client_arbiter.md
Name: ats21_client_arbiter

Overview:
Two-client front end for the ATS21 clock/alarm controller. Client A and client B each present a full command (ctrlA/ctrlB word pair), and this block arbitrates between them round-robin. It drives the single ATS21 req/ctrlA/ctrlB request port, waits for the ATS21 ready handshake (with a timeout), and returns stat/data to the owning client on a shared response bus.

Parameters:
CTRL_W, 16, width of each ctrl word
DATA_W, 24, width of ATS21 data (one bit per alarm)
STAT_W, 2, width of ATS21 stat
TIMEOUT, 64, max cycles in ISSUE waiting for ats_ready before error; legal range 2..65535
TO_W, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
clk  in  1  single design clock, all state on posedge
reset  in  1  asynchronous, active-high reset
a_req  in  1  client A request, level, held until a_done
a_ctrlA  in  CTRL_W  client A command word A, stable while a_req
a_ctrlB  in  CTRL_W  client A command word B
b_req  in  1  client B request
b_ctrlA  in  CTRL_W  client B command word A
b_ctrlB  in  CTRL_W  client B command word B
a_gnt  out  1  client A owns ATS21
b_gnt  out  1  client B owns ATS21
a_done  out  1  one-cycle pulse, response for A valid
b_done  out  1  one-cycle pulse, response for B valid
rsp_stat  out  STAT_W  response stat, qualified by a_done/b_done
rsp_data  out  DATA_W  response data, qualified by a_done/b_done
rsp_timeout  out  1  response was a timeout, qualified by done
busy  out  1  high in ISSUE and RESP
ats_req  out  1  to ATS21 req
ats_ctrlA  out  CTRL_W  to ATS21 ctrlA
ats_ctrlB  out  CTRL_W  to ATS21 ctrlB
ats_ready  in  1  from ATS21 ready
ats_stat  in  STAT_W  from ATS21 stat, valid when ats_ready
ats_data  in  DATA_W  from ATS21 data, valid when ats_ready

Behaviour:
- Reset (async, immediate, also mid-transaction): all outputs 0; state IDLE; last_owner=B, so A wins the first tie; timeout counter 0; latched ctrl 0.
- All outputs registered. FSM states: IDLE, ISSUE, RESP.
- IDLE, on a posedge with a_req|b_req:
  - Only one client requesting: grant that client.
  - Both requesting: grant the client that is not last_owner.
  - Latch the winner's ctrlA/ctrlB into ats_ctrlA/ats_ctrlB, then go to ISSUE.
  - Next cycle: ats_req=1, gnt of owner=1, busy=1.
  - Latency from req sampled to ats_req high: 1 cycle.
- ISSUE:
  - ats_req and ats_ctrl held constant.
  - ats_ready=1 at a posedge: capture ats_stat/ats_data, go to RESP.
  - Otherwise the counter increments. If the counter equals TIMEOUT-1 at that edge, go to RESP with stat=0, data=0, timeout flag=1.
  - ats_ready and timeout on the same edge: ready wins, timeout=0.
- RESP (exactly 1 cycle):
  - ats_req=0.
  - Owner's done=1; rsp_stat/rsp_data/rsp_timeout valid; gnt still high.
  - last_owner=owner; counter cleared. Next state IDLE, where done, gnt, busy and rsp_timeout return to 0.
  - rsp_stat/rsp_data hold their last value until the next RESP.
- Client drops req during ISSUE: ignored; the transaction completes and done still pulses.
- Client requirements:
  - Deassert req by the edge after observing done.
  - A req still high in the IDLE cycle after RESP is treated as a new request. With both clients requesting, the other client wins by round-robin.
- Non-owner req during ISSUE/RESP: no effect; it is evaluated in the next IDLE.
- Throughput: one command per 3 cycles minimum (IDLE, ISSUE, RESP) when ats_ready returns on the first ISSUE edge.
- Invariants: a_gnt&b_gnt never 1; a_done&b_done never 1; ats_req=1 only in ISSUE.
- ats_ready outside ISSUE: ignored.

Decomposition:
- Package ats21_pkg:
  - CTRL_W, DATA_W, STAT_W constants.
  - Enum arb_state_e {IDLE, ISSUE, RESP}.
  - Enum client_e {CLIENT_A, CLIENT_B}.
  - Packed struct ats_cmd_t {ctrlA, ctrlB}.
- Sub-module ats21_rr_arb2: combinational 2-way round-robin pick from (a_req, b_req, last_owner) -> winner, valid. FSM, timeout counter and registers stay in the top.

Test Plan:
1. Reset, a_req=1 with ctrlA=16'h1234, ctrlB=16'h0005; ats_ready at 2nd ISSUE cycle with stat=2'b01, data=24'h000003 -> ats_req high 1 cycle after req sampled, ats_ctrl=1234/0005, a_done pulse 1 cycle with rsp_stat=01, rsp_data=000003, rsp_timeout=0.
2. a_req and b_req asserted same cycle, both held, ready immediate -> grants A, B, A, B in order; no gnt overlap; each done is a single pulse.
3. b_req only, ats_ready never asserted, TIMEOUT=64 -> ats_req high exactly 64 cycles, then b_done with rsp_timeout=1, rsp_stat=0, rsp_data=0.
4. ats_ready asserted on the same edge the counter hits TIMEOUT-1 -> normal response, rsp_timeout=0.
5. reset asserted mid-ISSUE (no clock edge) -> ats_req, gnt and busy drop immediately; after release, a pending b_req and a_req tie is granted to A.
6. a_req dropped during ISSUE, and ats_ready pulses while in IDLE -> transaction completes with a_done; the stray ready produces no done and no ats_req.
